// File: rtl/f_unpool_pkg.sv
// Shared encodings for the unpool expansion block: FSM states and fill modes.
package f_unpool_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  typedef enum logic {
    MODE_REPEAT = 1'b0,
    MODE_ZERO   = 1'b1
  } mode_t;
endpackage

// File: rtl/f_unpool_wrapcounter.sv
// Loadable phase counter that wraps to zero after reaching a runtime limit.
module f_wrapcounter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    // >= rather than == so a count can never run past the limit
    else if (i_en)   r_cnt <= (r_cnt >= i_limit) ? '0 : r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/f_unpool.sv
// Unpool expansion: each sampled input value is replayed (or zero-padded) over S+1 cycles.
module f_unpool
  import f_unpool_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DELAY_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               running,
  input  logic [DELAY_W-1:0] strideMinusOne,
  input  logic [DELAY_W-1:0] delay0,
  input  logic               zeroFill,
  input  logic [DATA_W-1:0]  in0,
  output logic [DATA_W-1:0]  out0
);
  state_t              r_state;
  mode_t               r_mode;
  logic [DELAY_W-1:0]  r_s;
  logic [DELAY_W-1:0]  r_dcnt;
  logic [DATA_W-1:0]   r_hold;
  logic [DATA_W-1:0]   r_out;
  logic [DELAY_W-1:0]  w_phase;
  logic [DELAY_W-1:0]  w_next_s;
  logic [DELAY_W-1:0]  w_load_val;
  logic                w_run_cap, w_dly_cap, w_act_adv, w_capture, w_fill;

  // A capture happens in the run cycle (D=0), the last delay cycle, or ACTIVE phase 0
  assign w_run_cap = run && (delay0 == '0);
  assign w_dly_cap = !run && running && (r_state == ST_DELAY) && (r_dcnt == DELAY_W'(1));
  assign w_act_adv = !run && running && (r_state == ST_ACTIVE);
  assign w_capture = w_run_cap || w_dly_cap || (w_act_adv && (w_phase == '0));
  assign w_fill    = w_act_adv && (w_phase != '0);

  // The capture cycle is phase 0, so the counter is loaded with the phase that follows it
  assign w_next_s   = run ? strideMinusOne : r_s;
  assign w_load_val = (w_next_s == '0) ? '0 : DELAY_W'(1);

  f_wrapcounter #(.W(DELAY_W)) u_phase (
    .clk        (clk),
    .rst        (rst),
    .i_load     (run || w_dly_cap),
    .i_load_val (w_load_val),
    .i_en       (w_act_adv),
    .i_limit    (r_s),
    .o_cnt      (w_phase)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_REPEAT;
      r_s     <= '0;
      r_dcnt  <= '0;
    end else if (run) begin
      r_s     <= strideMinusOne;
      r_mode  <= mode_t'(zeroFill);
      r_dcnt  <= delay0;
      r_state <= (delay0 == '0) ? ST_ACTIVE : ST_DELAY;
    end else if (running && (r_state == ST_DELAY)) begin
      r_dcnt <= r_dcnt - 1'b1;
      if (r_dcnt == DELAY_W'(1)) r_state <= ST_ACTIVE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold <= '0;
      r_out  <= '0;
    end else if (w_capture) begin
      r_hold <= in0;
      r_out  <= in0;
    end else if (w_fill) begin
      r_out <= (r_mode == MODE_ZERO) ? '0 : r_hold;
    end
  end

  assign out0 = r_out;
endmodule

// File: tb/tb_f_unpool.sv
// Randomized and directed checks of f_unpool against a stream-index reference model.
module tb_f_unpool;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       running = 1'b0;
  logic [1:0] strideMinusOne = '0;
  logic [1:0] delay0 = '0;
  logic       zeroFill = 1'b0;
  logic [7:0] in0 = '0;
  logic [7:0] out0;

  int total = 0;
  int bad   = 0;

  // reference model: index k counts advancing stream cycles since the last run
  bit       m_busy;
  int       m_k, m_d, m_s;
  bit       m_z;
  logic [7:0] m_hold, m_out;

  f_unpool #(.DATA_W(8), .DELAY_W(2)) dut (
    .clk(clk), .rst(rst), .run(run), .running(running),
    .strideMinusOne(strideMinusOne), .delay0(delay0), .zeroFill(zeroFill),
    .in0(in0), .out0(out0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_k = 0; m_d = 0; m_s = 0; m_z = 0; m_hold = '0; m_out = '0;
  endtask

  task automatic model_cycle(input bit r, input bit rn, input logic [7:0] d,
                             input int dl, input int s, input bit z);
    int ph;
    if (r) begin
      m_busy = 1; m_k = 0; m_d = dl; m_s = s; m_z = z;
    end else if (!(m_busy && rn)) begin
      return;
    end
    if (m_k >= m_d) begin
      ph = (m_k - m_d) % (m_s + 1);
      if (ph == 0) begin
        m_hold = d; m_out = d;
      end else begin
        m_out = m_z ? 8'd0 : m_hold;
      end
    end
    m_k++;
  endtask

  task automatic step(input bit r, input bit rn, input logic [7:0] d,
                      input logic [1:0] dl, input logic [1:0] s, input bit z);
    run = r; running = rn; in0 = d; delay0 = dl; strideMinusOne = s; zeroFill = z;
    @(posedge clk);
    model_cycle(r, rn, d, int'(dl), int'(s), z);
    #1 chk("out0", out0, m_out);
  endtask

  // non-run cycle with junk config, which the block must ignore
  task automatic go(input bit rn, input logic [7:0] d);
    step(1'b0, rn, d, 2'($urandom), 2'($urandom), 1'($urandom));
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 chk("rst_async", out0, 8'd0);
    model_reset();
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk("reset", out0, 8'd0);
    @(negedge clk) rst = 1'b0;

    // running without run must not wake the block
    for (int i = 0; i < 3; i++) go(1'b1, 8'(50 + i));
    chk("idle", out0, 8'd0);

    // D=0 S=0 repeat: pure one-cycle delay
    step(1'b1, 1'b0, 8'd5, 2'd0, 2'd0, 1'b0);
    chk("d0s0_first", out0, 8'd5);
    for (int i = 0; i < 256; i++) go(1'b1, 8'(i));
    chk("d0s0_last", out0, 8'd255);

    // D=0 S=3 repeat ramp: each multiple of 4 held for 4 cycles
    step(1'b1, 1'b1, 8'd0, 2'd0, 2'd3, 1'b0);
    for (int i = 1; i < 64; i++) go(1'b1, 8'(i));
    chk("d0s3_ramp", out0, 8'd60);

    // D=3 S=1 zero-insert: capture at cycle 3
    do_reset();
    step(1'b1, 1'b0, 8'd10, 2'd3, 2'd1, 1'b1);
    go(1'b1, 8'd11);
    go(1'b1, 8'd12);
    chk("d3_pre", out0, 8'd0);
    go(1'b1, 8'd13);
    chk("d3_cap", out0, 8'd13);
    go(1'b1, 8'd14);
    chk("d3_zero", out0, 8'd0);
    for (int i = 0; i < 6; i++) go(1'b1, 8'(20 + i));

    // freeze at phase 2 for two cycles
    step(1'b1, 1'b1, 8'd77, 2'd0, 2'd3, 1'b0);
    go(1'b1, 8'd1);
    go(1'b0, 8'd2);
    go(1'b0, 8'd3);
    chk("freeze", out0, 8'd77);
    for (int i = 0; i < 6; i++) go(1'b1, 8'(90 + i));

    // mid-group restart with S=0, then mid-group reset
    step(1'b1, 1'b1, 8'd40, 2'd0, 2'd3, 1'b0);
    go(1'b1, 8'd41);
    step(1'b1, 1'b1, 8'd99, 2'd0, 2'd0, 1'b0);
    chk("restart", out0, 8'd99);
    go(1'b1, 8'd100);
    do_reset();
    for (int i = 0; i < 4; i++) go(1'b1, 8'(200 + i));
    chk("post_rst", out0, 8'd0);

    // sweep D with S=3: first capture lands exactly at cycle D
    for (int d = 0; d < 4; d++) begin
      do_reset();
      step(1'b1, 1'b1, 8'd100, 2'(d), 2'd3, 1'b0);
      for (int c = 1; c <= d; c++) go(1'b1, 8'(100 + c));
      chk("sweep_cap", out0, 8'(100 + d));
      for (int c = 0; c < 10; c++) go(1'b1, 8'(110 + c));
    end

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step(($urandom_range(0, 24) == 0), ($urandom_range(0, 4) != 0), 8'($urandom),
           2'($urandom), 2'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
